// File: rtl/vote_session_ctrl_pkg.sv
// Shared types and constants for the vote session controller: FSM states,
// winner codes and the default counter width.
package voting_pkg;

  localparam int CW_DEFAULT = 4;

  typedef enum logic [2:0] {
    IDLE,
    OPEN,
    BALLOT,
    COMMIT,
    RELEASE,
    TALLY,
    DONE
  } state_e;

  localparam logic [1:0] WIN_NONE = 2'b00;
  localparam logic [1:0] WIN_A    = 2'b01;
  localparam logic [1:0] WIN_B    = 2'b10;
  localparam logic [1:0] WIN_TIE  = 2'b11;

  // No votes at all is reported as "none" rather than as a tie.
  function automatic logic [1:0] win_code(input int unsigned a, input int unsigned b);
    if (a == 0 && b == 0) return WIN_NONE;
    if (a == b)           return WIN_TIE;
    if (a > b)            return WIN_A;
    return WIN_B;
  endfunction

endpackage

// File: rtl/vote_session_ctrl_if.sv
// Officer/voter panel and counter-side signals of the vote session controller.
// The controller uses the slave modport; whoever drives the panel uses master.
interface vote_session_ctrl_if #(
  parameter int CW = voting_pkg::CW_DEFAULT
) ();
  logic          open_poll;
  logic          close_poll;
  logic          ballot_issue;
  logic          btn_a;
  logic          btn_b;
  logic [CW-1:0] count_a;
  logic [CW-1:0] count_b;
  logic          vote_a;
  logic          vote_b;
  logic          count_clr;
  logic          poll_open;
  logic          ballot_ready;
  logic          vote_ack;
  logic          invalid;
  logic          timeout;
  logic          full;
  logic          result_valid;
  logic [1:0]    winner;

  modport slave (
    input  open_poll, close_poll, ballot_issue, btn_a, btn_b, count_a, count_b,
    output vote_a, vote_b, count_clr, poll_open, ballot_ready, vote_ack,
           invalid, timeout, full, result_valid, winner
  );

  modport master (
    output open_poll, close_poll, ballot_issue, btn_a, btn_b, count_a, count_b,
    input  vote_a, vote_b, count_clr, poll_open, ballot_ready, vote_ack,
           invalid, timeout, full, result_valid, winner
  );
endinterface

// File: rtl/vote_session_ctrl_btn_edge.sv
// Registers a synchronised button level and emits a one-cycle pulse on its
// rising edge, so a held button never counts twice.
module btn_edge (
  input  logic clk,
  input  logic reset,
  input  logic btn_i,
  output logic press_o
);
  logic btn_q;

  always_ff @(posedge clk) begin
    if (reset) btn_q <= 1'b0;
    else       btn_q <= btn_i;
  end

  assign press_o = btn_i & ~btn_q;
endmodule

// File: rtl/vote_session_ctrl.sv
// Two-candidate poll sequencer: arms one ballot at a time, turns button
// presses into single increment strobes and publishes the winner after close.
module vote_session_ctrl
  import voting_pkg::*;
#(
  parameter int CW      = CW_DEFAULT,
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  vote_session_ctrl_if.slave bus
);
  localparam int              TW         = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   COUNT_MAX  = '1;

  logic [1:0] btn;
  logic [1:0] press;
  logic       press_a;
  logic       press_b;

  assign btn = {bus.btn_b, bus.btn_a};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      btn_edge u_edge (
        .clk     (clk),
        .reset   (reset),
        .btn_i   (btn[gi]),
        .press_o (press[gi])
      );
    end
  endgenerate

  assign press_a = press[0];
  assign press_b = press[1];

  state_e        state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          choice_q, choice_d;   // 0 = A, 1 = B
  logic [1:0]    winner_q, winner_d;
  logic          timeout_q, timeout_d;
  logic          invalid_q, invalid_d;
  logic          full;

  assign full = (bus.count_a == COUNT_MAX) | (bus.count_b == COUNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      timer_q   <= '0;
      choice_q  <= 1'b0;
      winner_q  <= WIN_NONE;
      timeout_q <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      choice_q  <= choice_d;
      winner_q  <= winner_d;
      timeout_q <= timeout_d;
      invalid_q <= invalid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    choice_d  = choice_q;
    winner_d  = winner_q;
    timeout_d = 1'b0;
    invalid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.open_poll) state_d = OPEN;
      end
      OPEN: begin
        if (bus.close_poll) begin
          state_d = TALLY;
        end else if (bus.ballot_issue && !full) begin
          state_d = BALLOT;
          timer_d = '0;
        end
      end
      BALLOT: begin
        // Close voids the armed ballot; a double press is flagged but keeps it armed.
        invalid_d = ~bus.close_poll & press_a & press_b;
        if (bus.close_poll) begin
          state_d = TALLY;
        end else if (press_a ^ press_b) begin
          state_d  = COMMIT;
          choice_d = press_b;
        end else if (timer_q == TIMER_LAST) begin
          state_d   = OPEN;
          timeout_d = 1'b1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      COMMIT: begin
        state_d = bus.close_poll ? TALLY : RELEASE;
      end
      RELEASE: begin
        if (bus.close_poll)                state_d = TALLY;
        else if (!bus.btn_a && !bus.btn_b) state_d = OPEN;
      end
      TALLY: begin
        state_d  = DONE;
        winner_d = win_code(32'(bus.count_a), 32'(bus.count_b));
      end
      DONE: begin
        if (bus.open_poll) begin
          state_d  = OPEN;
          winner_d = WIN_NONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.vote_a       = (state_q == COMMIT) & ~choice_q;
  assign bus.vote_b       = (state_q == COMMIT) & choice_q;
  assign bus.vote_ack     = (state_q == COMMIT);
  assign bus.count_clr    = ~reset & bus.open_poll & ((state_q == IDLE) | (state_q == DONE));
  assign bus.poll_open    = (state_q == OPEN) | (state_q == BALLOT) |
                            (state_q == COMMIT) | (state_q == RELEASE);
  assign bus.ballot_ready = (state_q == BALLOT);
  assign bus.invalid      = invalid_q;
  assign bus.timeout      = timeout_q;
  assign bus.full         = full;
  assign bus.result_valid = (state_q == DONE);
  assign bus.winner       = winner_q;
endmodule

// File: tb/tb_vote_session_ctrl.sv
// Bench for vote_session_ctrl: directed session scenarios plus random stimulus,
// checked every cycle against a phase-level model of the poll rules.
module tb_vote_session_ctrl;
  localparam int CW      = 4;
  localparam int TIMEOUT = 16;
  localparam int CMAX    = (1 << CW) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  vote_session_ctrl_if #(.CW(CW)) bus ();

  vote_session_ctrl #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  int n_va   = 0;
  int n_vb   = 0;
  int cyc    = 0;

  // Counter datapath stand-in, with a preload hook to reach saturation quickly.
  logic [CW-1:0] cnt_a = '0, cnt_b = '0;
  logic          preload_en = 1'b0;
  logic [CW-1:0] preload_a = '0, preload_b = '0;
  assign bus.count_a = cnt_a;
  assign bus.count_b = cnt_b;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (reset || bus.count_clr) begin
      cnt_a <= '0;
      cnt_b <= '0;
    end else if (preload_en) begin
      cnt_a <= preload_a;
      cnt_b <= preload_b;
    end else begin
      if (bus.vote_a && cnt_a != CMAX[CW-1:0]) cnt_a <= cnt_a + 1'b1;
      if (bus.vote_b && cnt_b != CMAX[CW-1:0]) cnt_b <= cnt_b + 1'b1;
    end
    if (!reset) begin
      if (bus.vote_a) n_va <= n_va + 1;
      if (bus.vote_b) n_vb <= n_vb + 1;
    end
  end

  // Model: what the poll is doing, as independent flags and counters.
  bit m_open = 0, m_armed = 0, m_release = 0, m_tally = 0, m_done = 0;
  int m_age = 0, m_choice = 0, m_winner = 0;
  bit m_prev_a = 0, m_prev_b = 0, e_timeout = 0, e_invalid = 0;

  function automatic int rule_winner(int a, int b);
    if (a == 0 && b == 0) return 0;
    if (a == b) return 3;
    return (a > b) ? 1 : 2;
  endfunction

  always @(posedge clk) begin
    bit pa, pb, closing;
    int ca, cb;
    ca = int'(cnt_a);
    cb = int'(cnt_b);
    pa = bus.btn_a && !m_prev_a;
    pb = bus.btn_b && !m_prev_b;
    closing = bus.close_poll;
    e_timeout = 0;
    e_invalid = 0;
    if (reset) begin
      m_open = 0; m_armed = 0; m_release = 0; m_tally = 0; m_done = 0;
      m_age = 0; m_choice = 0; m_winner = 0; m_prev_a = 0; m_prev_b = 0;
    end else begin
      m_prev_a = bus.btn_a;
      m_prev_b = bus.btn_b;
      if (m_tally) begin
        m_tally = 0; m_done = 1; m_winner = rule_winner(ca, cb);
      end else if (m_choice != 0) begin
        m_choice = 0;
        if (closing) begin m_open = 0; m_tally = 1; end
        else m_release = 1;
      end else if (m_armed) begin
        if (closing) begin
          m_armed = 0; m_open = 0; m_tally = 1;
        end else begin
          if (pa && pb) e_invalid = 1;
          if (pa != pb) begin
            m_armed = 0; m_choice = pa ? 1 : 2;
          end else if (m_age == TIMEOUT - 1) begin
            m_armed = 0; e_timeout = 1;
          end else begin
            m_age++;
          end
        end
      end else if (m_release) begin
        if (closing) begin m_release = 0; m_open = 0; m_tally = 1; end
        else if (!bus.btn_a && !bus.btn_b) m_release = 0;
      end else if (m_open) begin
        if (closing) begin m_open = 0; m_tally = 1; end
        else if (bus.ballot_issue && !(ca == CMAX || cb == CMAX)) begin
          m_armed = 1; m_age = 0;
        end
      end else if (bus.open_poll) begin
        m_open = 1; m_done = 0; m_winner = 0;
      end
    end
  end

  function automatic logic [11:0] model_vec();
    bit idle_or_done, full_now;
    idle_or_done = !m_open && !m_tally;
    full_now = (int'(cnt_a) == CMAX) || (int'(cnt_b) == CMAX);
    return {m_choice == 1, m_choice == 2, m_choice != 0,
            idle_or_done && bus.open_poll && !reset,
            m_open, m_armed, e_invalid, e_timeout, full_now, m_done,
            2'(m_winner)};
  endfunction

  always @(negedge clk) begin
    logic [11:0] act, exp_v;
    act = {bus.vote_a, bus.vote_b, bus.vote_ack, bus.count_clr, bus.poll_open,
           bus.ballot_ready, bus.invalid, bus.timeout, bus.full, bus.result_valid,
           bus.winner};
    exp_v = model_vec();
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL cycle_outputs cyc=%0d got=%b expected=%b", cyc, act, exp_v);
    end
  end

  task automatic step(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(string name, int act, int exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic do_open();  bus.open_poll = 1;    step(); bus.open_poll = 0;    endtask
  task automatic do_close(); bus.close_poll = 1;   step(); bus.close_poll = 0;   endtask
  task automatic do_issue(); bus.ballot_issue = 1; step(); bus.ballot_issue = 0; endtask

  task automatic cast_vote(bit is_b);
    if (is_b) bus.btn_b = 1; else bus.btn_a = 1;
    step();
    bus.btn_a = 0; bus.btn_b = 0;
    step(2);
  endtask

  task automatic preload(int a, int b);
    preload_en = 1; preload_a = CW'(a); preload_b = CW'(b);
    step();
    preload_en = 0;
  endtask

  initial begin
    int va0, vb0;
    bus.open_poll = 0; bus.close_poll = 0; bus.ballot_issue = 0;
    bus.btn_a = 0; bus.btn_b = 0;
    reset = 1;
    step(2);
    reset = 0;
    step();
    chk("reset_poll_open", int'(bus.poll_open), 0);
    chk("reset_winner", int'(bus.winner), 0);

    // Full session: A, B, A then close.
    do_open();
    do_issue(); cast_vote(0);
    do_issue(); cast_vote(1);
    do_issue(); cast_vote(0);
    do_close();
    step();
    chk("session_strobes", n_va + n_vb, 3);
    chk("session_count_a", int'(cnt_a), 2);
    chk("session_count_b", int'(cnt_b), 1);
    chk("session_winner", int'(bus.winner), 1);
    chk("session_result_valid", int'(bus.result_valid), 1);

    // Held button through issue, then a second press inside RELEASE.
    do_open();
    va0 = n_va; vb0 = n_vb;
    bus.btn_a = 1;
    do_issue();
    step(3);
    chk("held_no_strobe", n_va - va0, 0);
    chk("held_still_armed", int'(bus.ballot_ready), 1);
    bus.btn_a = 0; step();
    bus.btn_a = 1; step();
    chk("held_repress_vote_a", int'(bus.vote_a), 1);
    step();
    bus.btn_b = 1; step();
    bus.btn_a = 0; bus.btn_b = 0; step();
    chk("release_press_ignored", (n_va - va0) * 10 + (n_vb - vb0), 10);

    // Simultaneous press then a clean B press.
    do_issue();
    bus.btn_a = 1; bus.btn_b = 1; step();
    chk("double_invalid", int'(bus.invalid), 1);
    chk("double_ready_kept", int'(bus.ballot_ready), 1);
    chk("double_no_ack", int'(bus.vote_ack), 0);
    bus.btn_a = 0; bus.btn_b = 0; step();
    chk("double_invalid_gone", int'(bus.invalid), 0);
    bus.btn_b = 1; step();
    chk("after_double_vote_b", int'(bus.vote_b), 1);
    bus.btn_b = 0; step(2);

    // Ballot expiry, then a stray press.
    va0 = n_va;
    do_issue();
    step(TIMEOUT - 1);
    chk("timeout_not_yet", int'(bus.timeout), 0);
    chk("timeout_still_ready", int'(bus.ballot_ready), 1);
    step();
    chk("timeout_pulse", int'(bus.timeout), 1);
    chk("timeout_back_open", int'(bus.poll_open) * 2 + int'(bus.ballot_ready), 2);
    bus.btn_a = 1; step(); bus.btn_a = 0; step(2);
    chk("timeout_press_ignored", n_va - va0, 0);

    // Saturation blocks ballots; winner encodings.
    preload(15, 3);
    chk("full_flag", int'(bus.full), 1);
    do_issue();
    chk("full_blocks_issue", int'(bus.ballot_ready), 0);
    do_close(); step();
    chk("full_winner_a", int'(bus.winner), 1);
    do_open(); preload(2, 2);
    do_close(); step();
    chk("tie_winner", int'(bus.winner), 3);
    do_open();
    do_close(); step();
    chk("empty_winner", int'(bus.winner), 0);

    // Close in the same cycle as a press voids the ballot.
    do_open(); do_issue();
    va0 = n_va;
    bus.btn_a = 1; bus.close_poll = 1; step();
    bus.btn_a = 0; bus.close_poll = 0;
    chk("close_press_no_ack", int'(bus.vote_ack), 0);
    chk("close_press_poll_shut", int'(bus.poll_open), 0);
    step();
    chk("close_press_result", int'(bus.result_valid), 1);
    chk("close_press_no_strobe", n_va - va0, 0);

    // Reset while a vote is committing.
    do_open(); do_issue();
    bus.btn_a = 1; step();
    chk("commit_strobe_a", int'(bus.vote_a), 1);
    bus.btn_a = 0; reset = 1; step(); reset = 0;
    chk("reset_commit_vote_a", int'(bus.vote_a), 0);
    chk("reset_commit_poll_open", int'(bus.poll_open), 0);
    chk("reset_commit_count_a", int'(cnt_a), 0);

    // Random traffic, checked cycle by cycle by the model.
    for (int i = 0; i < 4000; i++) begin
      bus.open_poll    = ($urandom_range(0, 15) == 0);
      bus.close_poll   = ($urandom_range(0, 59) == 0);
      bus.ballot_issue = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) bus.btn_a = ~bus.btn_a;
      if ($urandom_range(0, 3) == 0) bus.btn_b = ~bus.btn_b;
      reset = ($urandom_range(0, 499) == 0);
      step();
    end
    bus.open_poll = 0; bus.close_poll = 0; bus.ballot_issue = 0;
    bus.btn_a = 0; bus.btn_b = 0; reset = 0;
    step(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
